// File: rtl/dcp_mem_dump_if.sv
// Bundle of command, memory and RX/TX handshake signals for the memory-dump command processor.
interface dcp_mem_dump_if;
  // command selection and completion
  logic [7:0]  sel_mode;
  logic        finish;
  // memory read port
  logic        mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  // RX parser handshake
  logic        req_rx;
  logic        type_rx;
  logic [31:0] din_rx;
  logic        flag_rx;
  logic        ack_rx;
  // TX path handshake
  logic        req_tx;
  logic        type_tx;
  logic [31:0] dout;
  logic        ack_tx;

  // command processor side
  modport master (
    input  sel_mode,
    input  mem_dout,
    input  din_rx,
    input  flag_rx,
    input  ack_rx,
    input  ack_tx,
    output finish,
    output mem_sel,
    output mem_addr,
    output req_rx,
    output type_rx,
    output req_tx,
    output type_tx,
    output dout
  );

  // environment side: command source, memories, RX parser and TX serialiser
  modport slave (
    output sel_mode,
    output mem_dout,
    output din_rx,
    output flag_rx,
    output ack_rx,
    output ack_tx,
    input  finish,
    input  mem_sel,
    input  mem_addr,
    input  req_rx,
    input  type_rx,
    input  req_tx,
    input  type_tx,
    input  dout
  );
endinterface

// File: rtl/dcp_mem_dump.sv
// Debug-unit command processor: dumps data or instruction memory as text lines
// "<tag>-<addr>:[ ]<word>...CRLF" over the TX path. Each channel keeps its own
// resume address so a repeated command without a typed address continues the dump.
module dcp_mem_dump #(
  parameter int         NUM_LINES      = 1,
  parameter int         WORDS_PER_LINE = 8,
  parameter int         ADDR_STEP      = 1,
  parameter int         MEM_LAT        = 1,
  parameter bit         SEP_EN         = 1'b0,
  parameter logic [7:0] CMD_D          = 8'h44,
  parameter logic [7:0] CMD_I          = 8'h49
) (
  input logic            clk,
  input logic            rstn,
  dcp_mem_dump_if.master bus
);

  typedef enum logic [3:0] {
    IDLE,
    SCAN,
    TAG,
    DASH,
    ADDR,
    COLON,
    FETCH,
    SEP,
    WORD,
    CR,
    LF,
    DONE
  } state_t;

  // A fetch always takes at least one cycle, even for a combinational memory.
  localparam int          FETCH_LEN  = (MEM_LAT < 1) ? 1 : MEM_LAT;
  localparam logic [1:0]  FETCH_LAST = 2'(FETCH_LEN - 1);
  localparam logic [4:0]  WORDS_MAX  = 5'(WORDS_PER_LINE);
  localparam logic [4:0]  LINES_MAX  = 5'(NUM_LINES);
  localparam logic [31:0] STEP       = 32'(ADDR_STEP);

  // ASCII items printed by the fixed-format states
  localparam logic [7:0] CH_D     = 8'h44;
  localparam logic [7:0] CH_I     = 8'h49;
  localparam logic [7:0] CH_DASH  = 8'h2D;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  state_t      state_reg, state_next;
  logic        req_rx_reg, req_rx_next;
  logic        req_tx_reg, req_tx_next;
  logic        type_tx_reg, type_tx_next;
  logic [31:0] dout_reg, dout_next;
  logic        finish_reg, finish_next;
  logic        mem_sel_reg, mem_sel_next;
  logic [31:0] cur_addr_reg, cur_addr_next;
  logic [31:0] data_reg, data_next;
  logic [4:0]  line_cnt_reg, line_cnt_next;
  logic [4:0]  word_cnt_reg, word_cnt_next;
  logic [1:0]  fetch_cnt_reg, fetch_cnt_next;
  logic [31:0] last_addr_reg  [2];
  logic [31:0] last_addr_next [2];

  logic        en;
  logic        is_print;
  logic        tx_ack;
  logic [31:0] item_data;
  logic        item_type;
  logic [7:0]  tag_char;

  assign en       = (bus.sel_mode == CMD_D) || (bus.sel_mode == CMD_I);
  assign tag_char = mem_sel_reg ? CH_I : CH_D;

  // Item each print state sends; states that print nothing flag is_print low.
  always_comb begin
    item_data = 32'd0;
    item_type = 1'b0;
    is_print  = 1'b1;
    case (state_reg)
      TAG:     item_data = {24'd0, tag_char};
      DASH:    item_data = {24'd0, CH_DASH};
      ADDR: begin
        item_data = cur_addr_reg;
        item_type = 1'b1;
      end
      COLON:   item_data = {24'd0, CH_COLON};
      SEP:     item_data = {24'd0, CH_SPACE};
      WORD: begin
        item_data = data_reg;
        item_type = 1'b1;
      end
      CR:      item_data = {24'd0, CH_CR};
      LF:      item_data = {24'd0, CH_LF};
      default: is_print = 1'b0;
    endcase
  end

  // An acknowledge only counts while a request is actually outstanding.
  assign tx_ack = is_print && req_tx_reg && bus.ack_tx;

  // Next-state and registered-output logic of the dump sequencer.
  always_comb begin
    state_next        = state_reg;
    req_rx_next       = req_rx_reg;
    req_tx_next       = req_tx_reg;
    type_tx_next      = type_tx_reg;
    dout_next         = dout_reg;
    finish_next       = finish_reg;
    mem_sel_next      = mem_sel_reg;
    cur_addr_next     = cur_addr_reg;
    data_next         = data_reg;
    line_cnt_next     = line_cnt_reg;
    word_cnt_next     = word_cnt_reg;
    fetch_cnt_next    = fetch_cnt_reg;
    last_addr_next[0] = last_addr_reg[0];
    last_addr_next[1] = last_addr_reg[1];

    // Shared TX handshake: raise the request one cycle after entering a print
    // state with the item frozen in dout, drop it on the accepting ack.
    if (is_print && !req_tx_reg) begin
      req_tx_next  = 1'b1;
      dout_next    = item_data;
      type_tx_next = item_type;
    end
    if (tx_ack) begin
      req_tx_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (en) begin
          state_next     = SCAN;
          mem_sel_next   = (bus.sel_mode == CMD_I);
          line_cnt_next  = 5'd0;
          word_cnt_next  = 5'd0;
          fetch_cnt_next = 2'd0;
        end
      end
      SCAN: begin
        if (req_rx_reg && bus.ack_rx) begin
          req_rx_next   = 1'b0;
          cur_addr_next = bus.flag_rx ? last_addr_reg[mem_sel_reg] : bus.din_rx;
          state_next    = TAG;
        end else begin
          req_rx_next = 1'b1;
        end
      end
      TAG: begin
        if (tx_ack) state_next = DASH;
      end
      DASH: begin
        if (tx_ack) state_next = ADDR;
      end
      ADDR: begin
        if (tx_ack) state_next = COLON;
      end
      COLON: begin
        if (tx_ack) state_next = FETCH;
      end
      FETCH: begin
        // mem_addr has followed cur_addr since the previous WORD ack; sample
        // the memory once its latency has elapsed.
        if (fetch_cnt_reg == FETCH_LAST) begin
          data_next      = bus.mem_dout;
          fetch_cnt_next = 2'd0;
          state_next     = SEP_EN ? SEP : WORD;
        end else begin
          fetch_cnt_next = fetch_cnt_reg + 2'd1;
        end
      end
      SEP: begin
        if (tx_ack) state_next = WORD;
      end
      WORD: begin
        if (tx_ack) begin
          cur_addr_next = cur_addr_reg + STEP;
          if ((word_cnt_reg + 5'd1) < WORDS_MAX) begin
            word_cnt_next = word_cnt_reg + 5'd1;
            state_next    = FETCH;
          end else begin
            word_cnt_next = 5'd0;
            state_next    = CR;
          end
        end
      end
      CR: begin
        if (tx_ack) state_next = LF;
      end
      LF: begin
        if (tx_ack) begin
          line_cnt_next = line_cnt_reg + 5'd1;
          if ((line_cnt_reg + 5'd1) < LINES_MAX) begin
            state_next = TAG;
          end else begin
            // cur_addr already points at the first unprinted word
            last_addr_next[mem_sel_reg] = cur_addr_reg;
            finish_next                 = 1'b1;
            state_next                  = DONE;
          end
        end
      end
      DONE: begin
        finish_next = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Dropping the command abandons the dump without touching the resume address.
    if ((state_reg != IDLE) && !en) begin
      state_next        = IDLE;
      req_tx_next       = 1'b0;
      req_rx_next       = 1'b0;
      finish_next       = 1'b0;
      fetch_cnt_next    = 2'd0;
      last_addr_next[0] = last_addr_reg[0];
      last_addr_next[1] = last_addr_reg[1];
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      req_rx_reg    <= 1'b0;
      req_tx_reg    <= 1'b0;
      type_tx_reg   <= 1'b0;
      dout_reg      <= 32'd0;
      finish_reg    <= 1'b0;
      mem_sel_reg   <= 1'b0;
      cur_addr_reg  <= 32'd0;
      data_reg      <= 32'd0;
      line_cnt_reg  <= 5'd0;
      word_cnt_reg  <= 5'd0;
      fetch_cnt_reg <= 2'd0;
    end else begin
      state_reg     <= state_next;
      req_rx_reg    <= req_rx_next;
      req_tx_reg    <= req_tx_next;
      type_tx_reg   <= type_tx_next;
      dout_reg      <= dout_next;
      finish_reg    <= finish_next;
      mem_sel_reg   <= mem_sel_next;
      cur_addr_reg  <= cur_addr_next;
      data_reg      <= data_next;
      line_cnt_reg  <= line_cnt_next;
      word_cnt_reg  <= word_cnt_next;
      fetch_cnt_reg <= fetch_cnt_next;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_last
    // Resume address of channel gi (0 = data, 1 = instruction).
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) last_addr_reg[gi] <= 32'd0;
      else       last_addr_reg[gi] <= last_addr_next[gi];
    end
  end

  assign bus.req_rx   = req_rx_reg;
  assign bus.type_rx  = 1'b1;
  assign bus.req_tx   = req_tx_reg;
  assign bus.type_tx  = type_tx_reg;
  assign bus.dout     = dout_reg;
  assign bus.finish   = finish_reg;
  assign bus.mem_sel  = mem_sel_reg;
  assign bus.mem_addr = cur_addr_reg;

endmodule

// File: tb/tb_dcp_mem_dump.sv
// Bench for dcp_mem_dump: two instances (default parameters, and a multi-line /
// byte-step / separator / slow-memory variant) driven by a shared responder that
// plays memory, RX parser and TX serialiser; printed items are compared with a
// line-format reference model.
module tb_dcp_mem_dump;

  logic clk;
  logic rstn;

  logic [7:0]  sel_mode [2];
  logic [31:0] din_rx   [2];
  logic        flag_rx  [2];
  logic        ack_rx   [2];
  logic        ack_tx   [2];
  logic [31:0] mem_dout [2];
  logic        finish   [2];
  logic        mem_sel  [2];
  logic [31:0] mem_addr [2];
  logic        req_rx   [2];
  logic        type_rx  [2];
  logic        req_tx   [2];
  logic        type_tx  [2];
  logic [31:0] dout     [2];

  dcp_mem_dump_if bus [2] ();

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    assign bus[gi].sel_mode = sel_mode[gi];
    assign bus[gi].din_rx   = din_rx[gi];
    assign bus[gi].flag_rx  = flag_rx[gi];
    assign bus[gi].ack_rx   = ack_rx[gi];
    assign bus[gi].ack_tx   = ack_tx[gi];
    assign bus[gi].mem_dout = mem_dout[gi];
    assign finish[gi]   = bus[gi].finish;
    assign mem_sel[gi]  = bus[gi].mem_sel;
    assign mem_addr[gi] = bus[gi].mem_addr;
    assign req_rx[gi]   = bus[gi].req_rx;
    assign type_rx[gi]  = bus[gi].type_rx;
    assign req_tx[gi]   = bus[gi].req_tx;
    assign type_tx[gi]  = bus[gi].type_tx;
    assign dout[gi]     = bus[gi].dout;

    dcp_mem_dump #(
      .NUM_LINES      (gi == 0 ? 1 : 2),
      .WORDS_PER_LINE (gi == 0 ? 8 : 2),
      .ADDR_STEP      (gi == 0 ? 1 : 4),
      .MEM_LAT        (gi == 0 ? 1 : 3),
      .SEP_EN         (gi == 0 ? 1'b0 : 1'b1)
    ) u_dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus[gi])
    );
  end

  // per-instance configuration as seen by the reference model
  function automatic int p_lines(input int i);     return (i == 0) ? 1 : 2; endfunction
  function automatic int p_words(input int i);     return (i == 0) ? 8 : 2; endfunction
  function automatic logic [31:0] p_step(input int i); return (i == 0) ? 32'd1 : 32'd4; endfunction
  function automatic int p_lat(input int i);       return (i == 0) ? 1 : 3; endfunction
  function automatic bit p_sep(input int i);       return (i == 0) ? 1'b0 : 1'b1; endfunction

  // memory contents: distinct per channel and per address
  function automatic logic [31:0] mem_val(input logic ch, input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ (ch ? 32'h5A5A_0000 : 32'h0000_A5A5);
  endfunction

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // items captured from either TX port: {instance, type, data}
  logic [33:0] tx_q [$];
  int drop_err = 0;
  int stab_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment: memories with latency, RX parser, TX serialiser with random
  // ack delays and stray acks while no request is pending.
  initial begin
    logic [31:0] dly [2][3];
    logic [32:0] held [2];
    bit tx_pend [2];
    bit rx_pend [2];
    bit acked [2];
    int tx_wait [2];
    int rx_wait [2];
    for (int i = 0; i < 2; i++) begin
      ack_tx[i] = 1'b0; ack_rx[i] = 1'b0; mem_dout[i] = 32'd0;
      tx_pend[i] = 0; rx_pend[i] = 0; acked[i] = 0; tx_wait[i] = 0; rx_wait[i] = 0;
      held[i] = '0;
      for (int k = 0; k < 3; k++) dly[i][k] = 32'd0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        dly[i][2] = dly[i][1];
        dly[i][1] = dly[i][0];
        dly[i][0] = mem_addr[i];
        mem_dout[i] = mem_val(mem_sel[i], dly[i][p_lat(i) - 1]);

        ack_rx[i] = 1'b0;
        if (!req_rx[i]) rx_pend[i] = 0;
        else if (!rx_pend[i]) begin
          rx_pend[i] = 1;
          rx_wait[i] = $urandom_range(0, 3);
        end else if (rx_wait[i] == 0) begin
          ack_rx[i] = 1'b1;
          rx_pend[i] = 0;
        end else rx_wait[i]--;

        ack_tx[i] = 1'b0;
        if (acked[i] && req_tx[i]) drop_err++;
        acked[i] = 0;
        if (!req_tx[i]) begin
          tx_pend[i] = 0;
          if ($urandom_range(0, 5) == 0) ack_tx[i] = 1'b1;
        end else if (!tx_pend[i]) begin
          tx_q.push_back({1'(i), type_tx[i], dout[i]});
          held[i] = {type_tx[i], dout[i]};
          tx_pend[i] = 1;
          tx_wait[i] = (i == 0) ? $urandom_range(0, 3) : $urandom_range(5, 20);
        end else begin
          if ({type_tx[i], dout[i]} !== held[i]) stab_err++;
          if (tx_wait[i] == 0) begin
            ack_tx[i] = 1'b1;
            tx_pend[i] = 0;
            acked[i] = 1;
          end else tx_wait[i]--;
        end
      end
    end
  end

  // reference resume addresses [instance][channel]
  logic [31:0] m_last [2][2];

  function automatic logic [33:0] chr(input int i, input logic [7:0] c);
    return {1'(i), 1'b0, 24'd0, c};
  endfunction

  task automatic do_dump(input int i, input logic [7:0] cmd, input logic [31:0] din, input logic flag);
    logic [33:0] exp_q [$];
    logic [31:0] a;
    logic ch;
    int base;
    int cnt;
    ch = (cmd == 8'h49);
    a = flag ? m_last[i][ch] : din;
    for (int l = 0; l < p_lines(i); l++) begin
      exp_q.push_back(chr(i, ch ? 8'h49 : 8'h44));
      exp_q.push_back(chr(i, 8'h2D));
      exp_q.push_back({1'(i), 1'b1, a});
      exp_q.push_back(chr(i, 8'h3A));
      for (int w = 0; w < p_words(i); w++) begin
        if (p_sep(i)) exp_q.push_back(chr(i, 8'h20));
        exp_q.push_back({1'(i), 1'b1, mem_val(ch, a)});
        a = a + p_step(i);
      end
      exp_q.push_back(chr(i, 8'h0D));
      exp_q.push_back(chr(i, 8'h0A));
    end
    base = tx_q.size();
    din_rx[i] = din;
    flag_rx[i] = flag;
    sel_mode[i] = cmd;
    cnt = 0;
    while (!finish[i] && cnt < 6000) begin
      @(negedge clk);
      cnt++;
    end
    $display("dump inst=%0d cmd=%h din=%h flag=%0d items=%0d cycles=%0d", i, cmd, din, flag, tx_q.size() - base, cnt);
    check("finish_rise", finish[i], 1'b1);
    check("mem_sel", mem_sel[i], ch);
    check("item_count", tx_q.size() - base, exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (base + k < tx_q.size()) check($sformatf("item%0d", k), tx_q[base + k], exp_q[k]);
    repeat (3) @(negedge clk);
    check("finish_hold", finish[i], 1'b1);
    check("end_addr", mem_addr[i], a);
    m_last[i][ch] = a;
    sel_mode[i] = 8'h00;
    @(negedge clk);
    check("finish_clear", finish[i], 1'b0);
    @(negedge clk);
  endtask

  // Wait (bounded) until n items of the current dump have been requested.
  task automatic wait_items(input int base, input int n);
    int cnt;
    cnt = 0;
    while ((tx_q.size() - base) < n && cnt < 3000) begin
      @(negedge clk);
      cnt++;
    end
    check("progress", ((tx_q.size() - base) >= n), 1'b1);
  endtask

  task automatic check_quiet(input int i, input string tag);
    check({tag, "_req_tx"}, req_tx[i], 1'b0);
    check({tag, "_req_rx"}, req_rx[i], 1'b0);
    check({tag, "_finish"}, finish[i], 1'b0);
  endtask

  initial begin
    int base;
    int i;
    logic [7:0] cmd;
    logic [31:0] din;
    logic flag;
    rstn = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sel_mode[k] = 8'h00; din_rx[k] = 32'd0; flag_rx[k] = 1'b0;
      m_last[k][0] = 32'd0; m_last[k][1] = 32'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_quiet(k, "rst");
      check("rst_mem_sel", mem_sel[k], 1'b0);
      check("rst_mem_addr", mem_addr[k], 32'd0);
      check("rst_dout", dout[k], 32'd0);
      check("rst_type_tx", type_tx[k], 1'b0);
      check("type_rx", type_rx[k], 1'b1);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // basic dump, continuation, other channel
    do_dump(0, 8'h44, 32'h10, 1'b0);
    do_dump(0, 8'h44, 32'h0, 1'b1);
    do_dump(0, 8'h49, 32'h55, 1'b1);
    // multi-line byte-stepped dump with separators
    do_dump(1, 8'h44, 32'h100, 1'b0);
    // address wrap
    do_dump(0, 8'h44, 32'hFFFF_FFFE, 1'b0);
    do_dump(1, 8'h44, 32'hFFFF_FFFE, 1'b0);

    // abort while a data word is being sent: resume address must not move
    base = tx_q.size();
    din_rx[1] = 32'h4000; flag_rx[1] = 1'b0; sel_mode[1] = 8'h44;
    wait_items(base, 6);
    sel_mode[1] = 8'h00;
    @(negedge clk);
    $display("abort inst=1 after %0d items", tx_q.size() - base);
    check_quiet(1, "abort");
    repeat (2) @(negedge clk);
    do_dump(1, 8'h44, 32'h0, 1'b1);

    // randomized command mix
    for (int n = 0; n < 16; n++) begin
      i = $urandom_range(0, 1);
      cmd = ($urandom_range(0, 1) == 0) ? 8'h44 : 8'h49;
      flag = ($urandom_range(0, 2) == 0);
      din = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
      do_dump(i, cmd, din, flag);
    end

    // asynchronous reset in the middle of an I dump
    base = tx_q.size();
    din_rx[0] = 32'h1234_5678; flag_rx[0] = 1'b0; sel_mode[0] = 8'h49;
    wait_items(base, 3);
    #2 rstn = 1'b0;
    #1;
    $display("async reset inst=0 after %0d items", tx_q.size() - base);
    check_quiet(0, "arst");
    check("arst_mem_sel", mem_sel[0], 1'b0);
    check("arst_mem_addr", mem_addr[0], 32'd0);
    check("arst_dout", dout[0], 32'd0);
    check("arst_type_tx", type_tx[0], 1'b0);
    sel_mode[0] = 8'h00;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_last[k][0] = 32'd0; m_last[k][1] = 32'd0;
    end
    @(negedge clk);
    do_dump(1, 8'h44, 32'h77, 1'b1);
    do_dump(0, 8'h49, 32'h77, 1'b1);

    check("req_drop_after_ack", drop_err, 0);
    check("dout_stable_during_req", stab_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dcp_mem_dump.md
Name: dcp_mem_dump

Overview:
- Debug-unit command processor that dumps memory contents over the serial TX path.
- Serves two channels, data memory (command 'D') and instruction memory (command 'I'), selected by sel_mode.
- Parametrised in line count, words per line, address step, memory read latency and separator.
- Each channel remembers its next address, so a repeated command without an address continues the dump.

Parameters:
- NUM_LINES, 1, number of output lines per command (1..16).
- WORDS_PER_LINE, 8, 32-bit words printed per line (1..16).
- ADDR_STEP, 1, address increment per word (1 = word addressing, 4 = byte addressing).
- MEM_LAT, 1, cycles from mem_addr change to mem_dout valid (0..3).
- SEP_EN, 0, 1 = print ASCII space (0x20) before every data word.
- CMD_D, 8'h44, sel_mode code selecting the data-memory channel.
- CMD_I, 8'h49, sel_mode code selecting the instruction-memory channel.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- sel_mode  in  8  current command code
- finish  out  1  dump complete; held high until sel_mode leaves the command
- mem_sel  out  1  0 = data memory, 1 = instruction memory
- mem_addr  out  32  read address to memory
- mem_dout  in  32  read data from the selected memory
- req_rx  out  1  request an address from the RX parser
- type_rx  out  1  constant 1 (hex word)
- din_rx  in  32  parsed address
- flag_rx  in  1  1 = no address was typed
- ack_rx  in  1  RX done, one-cycle pulse
- req_tx  out  1  request transmission of dout
- type_tx  out  1  0 = ASCII char in dout[7:0], 1 = 32-bit hex word
- dout  out  32  item to transmit
- ack_tx  in  1  TX done, one-cycle pulse

Behaviour:
- Reset: all outputs 0, FSM IDLE, both last-address registers 0, all counters 0.
- en = (sel_mode==CMD_D) | (sel_mode==CMD_I).
- mem_sel is registered on leaving IDLE: 1 if sel_mode==CMD_I.
- Tag char: 'D' (0x44) or 'I' (0x49) according to mem_sel.
- Abort: if en=0 in any non-IDLE state, the next state is IDLE; req_tx, req_rx and finish clear; last address is not updated.
- States: IDLE, SCAN, TAG, DASH, ADDR, COLON, FETCH, SEP, WORD, CR, LF, DONE.
- IDLE: if en, go to SCAN and clear line/word counters.
- SCAN: req_rx=1 until ack_rx.
  - On ack_rx: cur_addr <= flag_rx ? last_addr[mem_sel] : din_rx; req_rx <= 0; go to TAG.
- TX handshake, used by every print state: dout/type_tx are registered and stable while req_tx=1.
  - req_tx rises the cycle after state entry.
  - On a cycle with ack_tx=1 and req_tx=1: req_tx <= 0 and the FSM advances.
  - ack_tx while req_tx=0 is ignored. Exactly one item is sent per state visit.
- Per-line sequence: TAG(tag char) -> DASH(0x2D) -> ADDR(cur_addr, type 1) -> COLON(0x3A).
- Per word: FETCH -> [SEP(0x20) if SEP_EN] -> WORD(mem data, type 1).
  - FETCH holds mem_addr=cur_addr for MEM_LAT cycles, then latches mem_dout into the data register.
  - With MEM_LAT=0, mem_dout is latched in the FETCH entry cycle. FETCH always lasts max(MEM_LAT,1) cycles.
  - On WORD ack: cur_addr <= cur_addr + ADDR_STEP (32-bit wrap, 0xFFFFFFFF+1 = 0); word_cnt++.
  - If word_cnt < WORDS_PER_LINE go to FETCH, else go to CR.
- Line end: CR(0x0D) -> LF(0x0A).
  - On LF ack: line_cnt++. If line_cnt < NUM_LINES, go to TAG (the new line's address is the current cur_addr); else go to DONE.
- DONE: last_addr[mem_sel] <= cur_addr (next unprinted address). finish=1 and stays 1 while en=1.
  - When en=0, go to IDLE with finish=0.
- The channels are independent: a D dump never modifies last_addr of I, and vice versa.
- mem_addr = cur_addr at all times.

Test Plan:
- Defaults, sel_mode=0x44, din_rx=0x10, flag_rx=0 -> TX sequence 'D','-',0x10,':', mem[0x10..0x17], 0x0D, 0x0A; finish=1; last_addr_D=0x18.
- Repeat 'D' with flag_rx=1 -> address printed is 0x18, words mem[0x18..0x1F]. Then sel_mode=0x49, flag_rx=1 -> tag 'I', address 0, mem_sel=1.
- NUM_LINES=2, WORDS_PER_LINE=2, ADDR_STEP=4, SEP_EN=1, din_rx=0x100 -> "D-100: w w CRLF D-108: w w CRLF"; final last_addr=0x110.
- din_rx=0xFFFFFFFE, WORDS_PER_LINE=4 -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0, 1; last_addr=2.
- MEM_LAT=3 with ack_tx delayed 5 to 20 random cycles -> each fetched word equals mem[addr]; req_tx drops the cycle after each ack; stray ack_tx pulses while req_tx=0 cause no skipped item.
- sel_mode changed to 0 mid-WORD -> IDLE next cycle, req_tx=0, finish=0, last_addr unchanged; async rstn mid-dump -> all outputs 0 immediately.
